// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: state encoding, shift limit
// and the shift-count clamp helper.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned MAX_SHIFT = 8;
  localparam int unsigned CNT_W     = 4;

  // A byte can only be shifted 8 times meaningfully; larger requests saturate.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
    if (cnt > CNT_W'(MAX_SHIFT)) begin
      return CNT_W'(MAX_SHIFT);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/shift_sequencer_tick.sv
// Rate divider: counts 0..TICK_DIV-1 while enabled and emits a one-cycle
// tick at the last count. Held at zero while clear is asserted.
module tick_gen #(
  parameter int TICK_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = ~clear && (count_q == LAST);

  // Next count: clear forces zero, the tick cycle wraps, otherwise advance.
  always_comb begin
    count_d = count_q;
    if (clear || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Divider register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for the 8-bit load/shift-right register: one load, then
// N paced shift strobes, then a done pulse. Outputs are registered decodes of
// the current state, so every control line is glitch-free toward the shifter
// and lags the internal state by one cycle.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [3:0] shift_count,
  input  logic       arith,
  input  logic       abort,
  output logic       ready,
  output logic       done,
  output logic       load_n,
  output logic [7:0] load_v,
  output logic       shiftR,
  output logic       ASR
);

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             arith_q, arith_d;

  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             load_n_q, load_n_d;
  logic [7:0]       load_v_q, load_v_d;
  logic             shift_r_q, shift_r_d;
  logic             asr_q, asr_d;

  logic             tick;

  // Divider only runs inside SHIFT; it restarts from zero on every entry.
  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != ST_SHIFT),
    .tick    (tick)
  );

  // State, captured command and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      arith_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      load_n_q    <= 1'b1;
      load_v_q    <= '0;
      shift_r_q   <= 1'b0;
      asr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      arith_q     <= arith_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      load_n_q    <= load_n_d;
      load_v_q    <= load_v_d;
      shift_r_q   <= shift_r_d;
      asr_q       <= asr_d;
    end
  end

  // Next-state logic. Start is gated by the visible ready so a request
  // during the done pulse is dropped even though the state is already IDLE.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    arith_d     = arith_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && ready_q) begin
          data_d      = data_in;
          remaining_d = clamp_count(shift_count);
          arith_d     = arith;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort || (remaining_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          remaining_d = remaining_q - 1'b1;
        end
        // A strobe coinciding with abort still counts; nothing follows it.
        if (abort || (tick && (remaining_q == CNT_W'(1)))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode of the current state; load and shift are mutually exclusive
  // because they come from different states.
  always_comb begin
    ready_d   = (state_q == ST_IDLE);
    done_d    = (state_q == ST_DONE);
    load_n_d  = (state_q != ST_LOAD);
    load_v_d  = (state_q == ST_LOAD) ? data_q : 8'h00;
    shift_r_d = (state_q == ST_SHIFT) && tick;
    asr_d     = (state_q == ST_SHIFT) && arith_q;
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign load_n = load_n_q;
  assign load_v = load_v_q;
  assign shiftR = shift_r_q;
  assign ASR    = asr_q;

endmodule
